// File: rtl/heart_pkg.sv
// Shared types and helpers for the heart (player soul) controller.
package heart_pkg;

    localparam int HP_W = 8;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_HURT  = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    // Subtract that floors at zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/heart_axis.sv
// One axis of heart movement: steps by +/-VELOCITY when enabled and
// saturates onto [LO, HI] rather than refusing or wrapping.
module heart_axis #(
    parameter int W        = 16,
    parameter int LO       = 0,
    parameter int HI       = 100,
    parameter int VELOCITY = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic [W-1:0] i_init,
    output logic [W-1:0] o_pos
);

    localparam logic signed [W+1:0] LO_S  = (W+2)'(LO);
    localparam logic signed [W+1:0] HI_S  = (W+2)'(HI);
    localparam logic signed [W+1:0] VEL_S = (W+2)'(VELOCITY);

    logic [W-1:0]        pos_reg;
    logic [W-1:0]        pos_next;
    logic signed [W+1:0] cur_s;
    logic signed [W+1:0] nx_s;

    assign cur_s = $signed({2'b00, pos_reg});

    // Two spare bits keep a step past either edge from wrapping before the clamp.
    always_comb begin
        nx_s = cur_s;
        if (i_inc) nx_s = nx_s + VEL_S;
        if (i_dec) nx_s = nx_s - VEL_S;
        pos_next = pos_reg;
        if (i_en) begin
            if (nx_s < LO_S)
                pos_next = LO_S[W-1:0];
            else if (nx_s > HI_S)
                pos_next = HI_S[W-1:0];
            else
                pos_next = nx_s[W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            pos_reg <= i_init;
        else
            pos_reg <= pos_next;
    end

    assign o_pos = pos_reg;

endmodule

// File: rtl/heart_ctrl.sv
// Player soul controller: clamped WASD movement inside the fight box,
// HP tracking with an invulnerable/blinking HURT window and a DEAD lock-out.
module heart_ctrl
    import heart_pkg::*;
#(
    parameter int W          = 16,
    parameter int F_WIDTH    = 150,
    parameter int F_HEIGHT   = 150,
    parameter int FX         = 245,
    parameter int FY         = 230,
    parameter int R          = 5,
    parameter int C_X        = 75,
    parameter int C_Y        = 75,
    parameter int VELOCITY   = 5,
    parameter int HP_MAX     = 20,
    parameter int DAMAGE     = 4,
    parameter int INV_FRAMES = 60,
    parameter int BLINK      = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ani_stb,
    input  logic            i_animate,
    input  logic            i_w_key,
    input  logic            i_a_key,
    input  logic            i_s_key,
    input  logic            i_d_key,
    input  logic            i_hit,
    output logic [W-1:0]    o_cx,
    output logic [W-1:0]    o_cy,
    output logic [W-1:0]    o_r,
    output logic [HP_W-1:0] o_hp,
    output logic            o_visible,
    output logic            o_hurt,
    output logic            o_dead
);

    localparam int INV_W = $clog2(INV_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK + 1);

    state_t           state_reg, state_next;
    logic [HP_W-1:0]  hp_reg, hp_next, hp_hit;
    logic [INV_W-1:0] inv_reg, inv_next;
    logic [BLK_W-1:0] blink_reg, blink_next;
    logic             vis_reg, vis_next;
    logic             step;
    logic             move_en;
    logic [1:0]       inc_keys;
    logic [1:0]       dec_keys;
    logic [W-1:0]     pos [2];

    assign step     = i_ani_stb & i_animate;
    assign move_en  = step & (state_reg != ST_DEAD);
    assign hp_hit   = sat_sub(hp_reg, HP_W'(DAMAGE));
    assign inc_keys = {i_s_key, i_d_key};
    assign dec_keys = {i_w_key, i_a_key};

    // Index 0 is x (d/a), index 1 is y (s/w).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int LO   = (gi == 0) ? FX + R : FY + R;
            localparam int HI   = (gi == 0) ? FX + F_WIDTH - R : FY + F_HEIGHT - R;
            localparam int INIT = (gi == 0) ? FX + C_X : FY + C_Y;
            heart_axis #(
                .W        (W),
                .LO       (LO),
                .HI       (HI),
                .VELOCITY (VELOCITY)
            ) u_axis (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_en   (move_en),
                .i_inc  (inc_keys[gi]),
                .i_dec  (dec_keys[gi]),
                .i_init (W'(INIT)),
                .o_pos  (pos[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_reg <= ST_ALIVE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ALIVE: if (i_hit) state_next = (hp_hit == '0) ? ST_DEAD : ST_HURT;
            ST_HURT:  if (step && inv_reg == INV_W'(1)) state_next = ST_ALIVE;
            ST_DEAD:  state_next = ST_DEAD;
            default:  state_next = ST_ALIVE;
        endcase
    end

    // HURT ignores i_hit, which is what turns a held hit level into a single hit.
    always_comb begin
        hp_next    = hp_reg;
        inv_next   = inv_reg;
        blink_next = blink_reg;
        vis_next   = vis_reg;
        case (state_reg)
            ST_ALIVE: begin
                if (i_hit) begin
                    hp_next = hp_hit;
                    if (hp_hit == '0) begin
                        vis_next = 1'b1;
                    end else begin
                        inv_next   = INV_W'(INV_FRAMES);
                        blink_next = BLK_W'(BLINK);
                        vis_next   = 1'b0;
                    end
                end
            end
            ST_HURT: begin
                if (step) begin
                    if (inv_reg == INV_W'(1)) begin
                        inv_next   = '0;
                        blink_next = '0;
                        vis_next   = 1'b1;
                    end else begin
                        inv_next = inv_reg - INV_W'(1);
                        if (blink_reg <= BLK_W'(1)) begin
                            blink_next = BLK_W'(BLINK);
                            vis_next   = ~vis_reg;
                        end else begin
                            blink_next = blink_reg - BLK_W'(1);
                        end
                    end
                end
            end
            default: begin
                hp_next  = '0;
                vis_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hp_reg    <= HP_W'(HP_MAX);
            inv_reg   <= '0;
            blink_reg <= '0;
            vis_reg   <= 1'b1;
        end else begin
            hp_reg    <= hp_next;
            inv_reg   <= inv_next;
            blink_reg <= blink_next;
            vis_reg   <= vis_next;
        end
    end

    always_comb begin
        o_hurt    = (state_reg == ST_HURT);
        o_dead    = (state_reg == ST_DEAD);
        o_visible = vis_reg;
        o_hp      = hp_reg;
        o_cx      = pos[0];
        o_cy      = pos[1];
        o_r       = W'(R);
    end

endmodule

// File: tb/tb_heart_ctrl.sv
// Directed scoreboard bench for heart_ctrl with default parameters.
module tb_heart_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ani_stb = 1'b0;
    logic        animate = 1'b1;
    logic        w_key = 1'b0, a_key = 1'b0, s_key = 1'b0, d_key = 1'b0;
    logic        hit = 1'b0;
    logic [15:0] cx, cy, r;
    logic [7:0]  hp;
    logic        visible, hurt, dead;

    heart_ctrl dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ani_stb (ani_stb),
        .i_animate (animate),
        .i_w_key   (w_key),
        .i_a_key   (a_key),
        .i_s_key   (s_key),
        .i_d_key   (d_key),
        .i_hit     (hit),
        .o_cx      (cx),
        .o_cy      (cy),
        .o_r       (r),
        .o_hp      (hp),
        .o_visible (visible),
        .o_hurt    (hurt),
        .o_dead    (dead)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] cx;
        logic [15:0] cy;
        logic [7:0]  hp;
        logic        vis;
        logic        hurt;
        logic        dead;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model of the expected outputs.
    int   e_cx, e_cy, e_hp;
    logic e_vis, e_hurt, e_dead;

    function automatic int clampv(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        e_cx = 320; e_cy = 305; e_hp = 20;
        e_vis = 1'b1; e_hurt = 1'b0; e_dead = 1'b0;
    endtask

    task automatic model_move();
        if (!e_dead) begin
            e_cx = clampv(e_cx + (d_key ? 5 : 0) - (a_key ? 5 : 0), 250, 390);
            e_cy = clampv(e_cy + (s_key ? 5 : 0) - (w_key ? 5 : 0), 235, 375);
        end
    endtask

    task automatic set_keys(input logic w, input logic a, input logic s, input logic d);
        w_key = w; a_key = a; s_key = s; d_key = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s %s: observed %0d expected %0d", tag, fld, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.cx = 16'(e_cx); e.cy = 16'(e_cy); e.hp = 8'(e_hp);
        e.vis = e_vis; e.hurt = e_hurt; e.dead = e_dead;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "cx", 32'(cx), 32'(e.cx));
        cmp(e.tag, "cy", 32'(cy), 32'(e.cy));
        cmp(e.tag, "hp", 32'(hp), 32'(e.hp));
        cmp(e.tag, "visible", 32'(visible), 32'(e.vis));
        cmp(e.tag, "hurt", 32'(hurt), 32'(e.hurt));
        cmp(e.tag, "dead", 32'(dead), 32'(e.dead));
        $display("[%0t] %s cx=%0d cy=%0d hp=%0d vis=%0b hurt=%0b dead=%0b",
                 $time, e.tag, cx, cy, hp, visible, hurt, dead);
    endtask

    // Expected values go on the queue as the stimulus is applied, then come off after the edge.
    task automatic cycle(input string tag);
        push_exp(tag);
        tick();
        check();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        cycle(tag);
        rst = 1'b0;
    endtask

    task automatic do_step(input string tag);
        ani_stb = 1'b1;
        model_move();
        cycle(tag);
        ani_stb = 1'b0;
    endtask

    task automatic do_hit(input string tag);
        hit = 1'b1;
        e_hp = (e_hp > 4) ? e_hp - 4 : 0;
        if (e_hp == 0) begin
            e_dead = 1'b1; e_vis = 1'b1; e_hurt = 1'b0;
        end else begin
            e_hurt = 1'b1; e_vis = 1'b0;
        end
        cycle(tag);
        hit = 1'b0;
    endtask

    // Runs the invulnerability window; an extra hit lands on step 30 when requested.
    task automatic hurt_window(input bit check_each, input bit hit_at_30);
        for (int k = 1; k <= 60; k++) begin
            hit = (hit_at_30 && k == 30);
            e_hurt = (k < 60);
            e_vis  = (k < 60) ? (((k / 4) % 2) == 1) : 1'b1;
            if (check_each || k == 60) begin
                do_step($sformatf("hurt_step%0d", k));
            end else begin
                ani_stb = 1'b1;
                tick();
                ani_stb = 1'b0;
            end
            hit = 1'b0;
        end
    endtask

    initial begin
        // 1: reset state, then walk left into the wall
        do_reset("reset");
        n_cmp++;
        assert (r === 16'd5) else begin
            n_bad++;
            $error("FAIL radius: observed %0d expected 5", r);
        end
        set_keys(0, 1, 0, 0);
        for (int i = 1; i <= 20; i++) do_step($sformatf("left%0d", i));

        // 2: opposite keys cancel, diagonal, no strobe means no motion
        do_reset("reset2");
        set_keys(0, 1, 0, 1);
        for (int i = 1; i <= 3; i++) do_step($sformatf("a_d%0d", i));
        set_keys(1, 0, 0, 1);
        for (int i = 1; i <= 3; i++) do_step($sformatf("w_d%0d", i));
        for (int i = 0; i < 100; i++) tick();
        cycle("hold_no_stb");
        animate = 1'b0;
        ani_stb = 1'b1;
        cycle("stb_no_animate");
        ani_stb = 1'b0;
        animate = 1'b1;
        set_keys(0, 0, 1, 1);
        for (int i = 1; i <= 20; i++) do_step($sformatf("down_right%0d", i));
        set_keys(0, 0, 0, 0);

        // 3: first hit, paused countdown, blinking, ignored hit during HURT
        do_hit("hit1");
        animate = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            ani_stb = 1'b1;
            cycle($sformatf("paused%0d", i));
        end
        ani_stb = 1'b0;
        animate = 1'b1;
        hurt_window(1'b1, 1'b1);

        // 4: further hits down to death; lethal hit shares its clk with a move
        for (int h = 2; h <= 4; h++) begin
            do_hit($sformatf("hit%0d", h));
            hurt_window(1'b0, 1'b0);
        end
        set_keys(0, 1, 0, 0);
        hit = 1'b1;
        ani_stb = 1'b1;
        model_move();
        e_hp = 0; e_dead = 1'b1; e_hurt = 1'b0; e_vis = 1'b1;
        cycle("lethal_step");
        for (int i = 1; i <= 5; i++) do_step($sformatf("dead%0d", i));
        hit = 1'b0;
        set_keys(0, 0, 0, 0);

        // 5: reset out of DEAD and out of mid-HURT
        do_reset("reset_dead");
        do_hit("hit_pre_reset");
        for (int i = 0; i < 30; i++) begin
            ani_stb = 1'b1;
            tick();
        end
        ani_stb = 1'b0;
        do_reset("reset_hurt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
